// File: rtl/sequenciador_envase.sv
// sequenciador_envase: bottling station sequencer that moves, fills, caps and ejects bottles and counts them per batch.
// Ports: CLK/reset (sync, active-high), Start run level, SensorPos bottle in place, SensorNivel level reached;
// Motor/Valvula/Vedacao actuators, ContGarrafas bottles in batch, Lotes batches (saturating at 99),
// LoteCompleto batch pulse, AlarmeNivel fill-timeout fault.
module sequenciador_envase #(
    parameter int FILL_TIMEOUT = 20,
    parameter int CAP_CYCLES   = 4,
    parameter int BATCH_SIZE   = 12
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Start,
    input  logic       SensorPos,
    input  logic       SensorNivel,
    output logic       Motor,
    output logic       Valvula,
    output logic       Vedacao,
    output logic [3:0] ContGarrafas,
    output logic [6:0] Lotes,
    output logic       LoteCompleto,
    output logic       AlarmeNivel
);
    typedef enum logic [2:0] {IDLE, MOVE, FILL, CAP, EXIT, FAULT} state_t;
    localparam logic [7:0] FILL_LAST  = 8'(FILL_TIMEOUT - 1);
    localparam logic [7:0] CAP_LAST   = 8'(CAP_CYCLES - 1);
    localparam logic [3:0] BATCH_LAST = 4'(BATCH_SIZE - 1);
    state_t state, ns;
    logic [7:0] t;
    logic bottle, wrap;
    always_comb begin
        ns = IDLE;
        case (state)
            IDLE:    ns = Start ? MOVE : IDLE;
            MOVE:    ns = !Start ? IDLE : SensorPos ? FILL : MOVE;
            FILL:    ns = SensorNivel ? CAP : (t == FILL_LAST) ? FAULT : FILL;
            CAP:     ns = (t == CAP_LAST) ? EXIT : CAP;
            EXIT:    ns = SensorPos ? EXIT : Start ? MOVE : IDLE;
            FAULT:   ns = Start ? FAULT : IDLE;
            default: ns = IDLE;
        endcase
    end
    assign bottle = (state == CAP) && (ns == EXIT);
    assign wrap   = bottle && (ContGarrafas == BATCH_LAST);
    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            t            <= 8'd0;
            ContGarrafas <= 4'd0;
            Lotes        <= 7'd0;
            LoteCompleto <= 1'b0;
            Motor        <= 1'b0;
            Valvula      <= 1'b0;
            Vedacao      <= 1'b0;
            AlarmeNivel  <= 1'b0;
        end else begin
            state        <= ns;
            t            <= (ns == state && (state == FILL || state == CAP)) ? t + 8'd1 : 8'd0;
            ContGarrafas <= wrap ? 4'd0 : bottle ? ContGarrafas + 4'd1 : ContGarrafas;
            Lotes        <= (wrap && Lotes != 7'd99) ? Lotes + 7'd1 : Lotes;
            LoteCompleto <= wrap;
            Motor        <= (ns == MOVE) || (ns == EXIT);
            Valvula      <= ns == FILL;
            Vedacao      <= ns == CAP;
            AlarmeNivel  <= ns == FAULT;
        end
    end
endmodule

// File: tb/tb_sequenciador_envase.sv
// tb_sequenciador_envase: directed self-checking bench for the bottling sequencer.
module tb_sequenciador_envase;
    logic       CLK = 1'b0;
    logic       reset, Start, SensorPos, SensorNivel;
    logic       Motor, Valvula, Vedacao, LoteCompleto, AlarmeNivel;
    logic [3:0] ContGarrafas;
    logic [6:0] Lotes;
    int vecs = 0, errs = 0, pulses = 0;
    int vc, cc, p0;

    sequenciador_envase dut (
        .CLK(CLK), .reset(reset), .Start(Start), .SensorPos(SensorPos), .SensorNivel(SensorNivel),
        .Motor(Motor), .Valvula(Valvula), .Vedacao(Vedacao), .ContGarrafas(ContGarrafas),
        .Lotes(Lotes), .LoteCompleto(LoteCompleto), .AlarmeNivel(AlarmeNivel)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (!reset && LoteCompleto === 1'b1) pulses++;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // From FILL index 0: raise the level sensor at index lvl, count valve then capper cycles.
    task automatic fill_cap(input int lvl, output int v, output int c);
        v = 0;
        while (Valvula === 1'b1 && v < 300) begin
            SensorNivel = (v == lvl);
            tick;
            v++;
        end
        SensorNivel = 1'b0;
        c = 0;
        while (Vedacao === 1'b1 && c < 300) begin
            tick;
            c++;
        end
    endtask

    // From MOVE: fastest complete bottle, ending back in MOVE.
    task automatic bottle;
        int v, c;
        SensorPos = 1'b1;
        tick;
        fill_cap(0, v, c);
        SensorPos = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; SensorPos = 1'b0; SensorNivel = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick;
        chk("init_outputs", {Motor, Valvula, Vedacao, AlarmeNivel, LoteCompleto}, 0);
        chk("init_counters", {ContGarrafas, Lotes}, 0);

        // nominal bottle
        Start = 1'b1;
        tick;
        chk("start_motor", Motor, 1);
        tick; tick;
        SensorPos = 1'b1;
        tick;
        chk("fill_entry", {Motor, Valvula}, 2'b01);
        fill_cap(5, vc, cc);
        chk("nom_valve_cycles", vc, 6);
        chk("nom_cap_cycles", cc, 4);
        chk("nom_exit_motor", Motor, 1);
        chk("nom_count", ContGarrafas, 1);
        tick;
        SensorPos = 1'b0;
        tick;
        chk("nom_back_motor", Motor, 1);
        SensorPos = 1'b1;
        tick;
        chk("nom_back_fill", Valvula, 1);

        // reset during FILL
        reset = 1'b1;
        tick;
        chk("rst_outputs", {Motor, Valvula, Vedacao, AlarmeNivel, LoteCompleto}, 0);
        chk("rst_counters", {ContGarrafas, Lotes}, 0);
        tick;
        reset = 1'b0; Start = 1'b0; SensorPos = 1'b0;
        tick; tick;
        chk("rst_idle_hold", {Motor, Valvula, Vedacao, AlarmeNivel}, 0);

        // batch wrap
        Start = 1'b1;
        tick;
        p0 = pulses;
        for (int i = 0; i < 11; i++) bottle();
        chk("batch_11", ContGarrafas, 11);
        SensorPos = 1'b1;
        tick;
        fill_cap(0, vc, cc);
        chk("wrap_count", ContGarrafas, 0);
        chk("wrap_pulse", LoteCompleto, 1);
        chk("wrap_lotes", Lotes, 1);
        tick;
        chk("wrap_pulse_end", LoteCompleto, 0);
        SensorPos = 1'b0;
        tick;
        chk("wrap_pulse_once", pulses - p0, 1);
        bottle();
        chk("bottle13", ContGarrafas, 1);

        // saturation at 99 batches
        for (int i = 0; i < 11 + 97 * 12; i++) bottle();
        chk("lotes_99", Lotes, 99);
        chk("lotes_99_count", ContGarrafas, 0);
        for (int i = 0; i < 12; i++) bottle();
        chk("lotes_sat", Lotes, 99);
        chk("pulses_total", pulses, 100);

        // fill timeout
        bottle();
        SensorPos = 1'b1;
        tick;
        fill_cap(1000, vc, cc);
        chk("to_valve_cycles", vc, 20);
        chk("to_no_cap", cc, 0);
        chk("to_alarm", {AlarmeNivel, Motor, Valvula, Vedacao}, 4'b1000);
        tick;
        chk("to_alarm_hold", AlarmeNivel, 1);
        Start = 1'b0;
        tick;
        chk("to_ack_idle", {AlarmeNivel, Motor}, 0);
        chk("to_count_kept", ContGarrafas, 1);
        Start = 1'b1;
        tick;
        chk("retry_move", Motor, 1);
        tick;
        chk("retry_fill", Valvula, 1);

        // level and timeout together
        fill_cap(19, vc, cc);
        chk("sim_valve_cycles", vc, 20);
        chk("sim_cap_cycles", cc, 4);
        chk("sim_no_alarm", AlarmeNivel, 0);
        chk("sim_count", ContGarrafas, 2);
        SensorPos = 1'b0;
        tick;

        // stop mid-cycle
        SensorPos = 1'b1;
        tick;
        Start = 1'b0;
        fill_cap(3, vc, cc);
        chk("stop_valve_cycles", vc, 4);
        chk("stop_cap_cycles", cc, 4);
        chk("stop_count", ContGarrafas, 3);
        chk("stop_exit_motor", Motor, 1);
        SensorPos = 1'b0;
        tick;
        chk("stop_idle", Motor, 0);
        tick;
        chk("stop_idle_hold", Motor, 0);
        Start = 1'b1;
        tick;
        chk("move_again", Motor, 1);
        Start = 1'b0;
        tick;
        chk("move_stop_idle", Motor, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
